carregador_programa: RTL and testbench

Program loader that writes the instruction memory that the fetch path reads.
- Receives a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the processor (PC, instruction register) frozen via cpu_hold until the load completes.
- Sits between the external byte source and the instruction memory write port, alongside the fetch path.

---
 rtl/carregador_programa.sv | 167 ++++++++++++++++
 tb/tb_carregador_programa.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
`default_nettype none
// ---------------------------------------------------------------------------
// carregador_programa : byte-stream program loader for the instruction memory;
// keeps the CPU frozen until the load ends. Option macro: CHECKSUM_EN. Rev 1.0
// ---------------------------------------------------------------------------
module carregador_programa #(
   parameter int ADDR_W  = 5,
   parameter int N_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              restart,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_endr,
   output logic [31:0]       mem_din,
   output logic              cpu_hold,
   output logic              done,
   output logic              erro
);
   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(N_WORDS);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERROR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

   state_t            state_q;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] widx_q;
   logic [1:0]        bidx_q;
   logic [23:0]       word_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_endr_q;
   logic [31:0]       mem_din_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              erro_q;
`ifdef CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic [ADDR_W:0] hdr_cnt;
   logic            hdr_ok;
   logic            xfer;
   logic            last_word;

`ifdef CHECKSUM_EN
   assign byte_ready = (state_q == S_IDLE) || (state_q == S_RECV) || (state_q == S_CHECK);
`else
   assign byte_ready = (state_q == S_IDLE) || (state_q == S_RECV);
`endif

   assign xfer      = byte_valid && byte_ready;
   assign hdr_cnt   = byte_data[ADDR_W:0];
   // Bits above the count field must be zero, otherwise the header is malformed.
   assign hdr_ok    = (hdr_cnt != '0) && (hdr_cnt <= MAX_CNT) &&
                      ((byte_data >> (ADDR_W + 1)) == 8'd0);
   assign last_word = ({1'b0, widx_q} == (count_q - 1'b1));

   assign mem_we   = mem_we_q;
   assign mem_endr = mem_endr_q;
   assign mem_din  = mem_din_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign erro     = erro_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         widx_q     <= '0;
         bidx_q     <= '0;
         word_q     <= '0;
         mem_we_q   <= 1'b0;
         mem_endr_q <= '0;
         mem_din_q  <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         erro_q     <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  if (hdr_ok) begin
                     state_q <= S_RECV;
                     count_q <= hdr_cnt;
                     widx_q  <= '0;
                     bidx_q  <= '0;
`ifdef CHECKSUM_EN
                     csum_q  <= byte_data;
`endif
                  end else begin
                     state_q <= S_ERROR;
                     erro_q  <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (xfer) begin
`ifdef CHECKSUM_EN
                  csum_q <= csum_q ^ byte_data;
`endif
                  bidx_q <= bidx_q + 2'd1;
                  // Lower three bytes shift in LSB first; the fourth completes the word.
                  if (bidx_q == 2'd3) begin
                     state_q    <= S_WRITE;
                     mem_we_q   <= 1'b1;
                     mem_endr_q <= widx_q;
                     mem_din_q  <= {byte_data, word_q};
                  end else begin
                     word_q <= {byte_data, word_q[23:8]};
                  end
               end
            end
            S_WRITE: begin
               mem_we_q <= 1'b0;
               if (last_word) begin
`ifdef CHECKSUM_EN
                  state_q    <= S_CHECK;
`else
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
`endif
               end else begin
                  widx_q  <= widx_q + 1'b1;
                  state_q <= S_RECV;
               end
            end
`ifdef CHECKSUM_EN
            S_CHECK: begin
               if (xfer) begin
                  if (byte_data == csum_q) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     cpu_hold_q <= 1'b0;
                  end else begin
                     state_q <= S_ERROR;
                     erro_q  <= 1'b1;
                  end
               end
            end
`endif
            S_DONE, S_ERROR: begin
               if (restart) begin
                  state_q    <= S_IDLE;
                  cpu_hold_q <= 1'b1;
                  done_q     <= 1'b0;
                  erro_q     <= 1'b0;
                  widx_q     <= '0;
                  bidx_q     <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_carregador_programa.sv
`default_nettype none
// Testbench for carregador_programa: directed and randomized loads checked
// against a byte-stream reference model. Honours CHECKSUM_EN like the design.
module tb_carregador_programa;
   localparam int ADDR_W  = 5;
   localparam int N_WORDS = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              restart = 1'b0;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_endr;
   logic [31:0]       mem_din;
   logic              cpu_hold;
   logic              done;
   logic              erro;

   carregador_programa #(.ADDR_W(ADDR_W), .N_WORDS(N_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .restart    (restart),
      .mem_we     (mem_we),
      .mem_endr   (mem_endr),
      .mem_din    (mem_din),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .erro       (erro)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Write monitor plus ready/write-enable consistency during an active load
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   bit                in_load = 1'b0;
   logic [31:0]       tw[N_WORDS];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_endr);
         wr_data.push_back(mem_din);
      end
      if (in_load) check("ready_low_only_in_write", {31'b0, byte_ready}, {31'b0, ~mem_we});
   end

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (byte_ready !== 1'b1) begin
         check("send_timeout", 32'd0, 32'd1);
         byte_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 byte_valid = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic e_rdy, input logic e_hold,
                               input logic e_done, input logic e_erro);
      check({tag, "_ready"}, {31'b0, byte_ready}, {31'b0, e_rdy});
      check({tag, "_hold"},  {31'b0, cpu_hold},   {31'b0, e_hold});
      check({tag, "_done"},  {31'b0, done},       {31'b0, e_done});
      check({tag, "_erro"},  {31'b0, erro},       {31'b0, e_erro});
   endtask

   task automatic check_reset_vals(input string tag);
      check_status(tag, 1'b1, 1'b1, 1'b0, 1'b0);
      check({tag, "_we"},   {31'b0, mem_we}, 32'd0);
      check({tag, "_endr"}, 32'(mem_endr),   32'd0);
      check({tag, "_din"},  mem_din,         32'd0);
   endtask

   task automatic pulse_restart(input string tag);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check_status(tag, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Reference: stream = header, words LSB first, optional XOR byte; expected writes are tw[0..cnt-1]
   task automatic do_load(input int cnt, input int gap, input bit bad_cs, input string tag);
      logic [7:0] s[$];
      logic [7:0] x;
      bit         exp_err;
      s.push_back(8'(cnt));
      for (int w = 0; w < cnt; w++)
         for (int k = 0; k < 4; k++) s.push_back(8'(tw[w] >> (8 * k)));
      exp_err = 1'b0;
`ifdef CHECKSUM_EN
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      s.push_back(bad_cs ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
      exp_err = bad_cs;
`else
      x = 8'(bad_cs);
`endif
      wr_addr.delete();
      wr_data.delete();
      in_load = 1'b1;
      foreach (s[i]) begin
         send_byte(s[i]);
         if (i == s.size() - 1) in_load = 1'b0;
         else repeat (gap) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(cnt));
      for (int i = 0; i < cnt && i < wr_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), wr_data[i], tw[i]);
      end
      check_status({tag, "_end"}, 1'b0, exp_err, ~exp_err, exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int h;
      bit valid;

      // Reset values while held and after release
      repeat (2) @(negedge clk);
      check_reset_vals("rst_low");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_rel");

      // Single word with exact write latency
      send_byte(8'h01);
      send_byte(8'h13);
      send_byte(8'h00);
      send_byte(8'h50);
      send_byte(8'h00);
      @(negedge clk);
      check("t1_we",    {31'b0, mem_we},  32'd1);
      check("t1_endr",  32'(mem_endr),    32'd0);
      check("t1_din",   mem_din,          32'h0050_0013);
      check("t1_ready", {31'b0, byte_ready}, 32'd0);
      @(negedge clk);
      check("t1_we_off", {31'b0, mem_we}, 32'd0);
`ifdef CHECKSUM_EN
      check_status("t1_check", 1'b1, 1'b1, 1'b0, 1'b0);
      send_byte(8'h42);
      @(negedge clk);
`endif
      check_status("t1_done", 1'b0, 1'b0, 1'b1, 1'b0);
      pulse_restart("t1_rs");

`ifdef CHECKSUM_EN
      // Wrong checksum: error, but the word is still written
      tw[0] = 32'h0050_0013;
      wr_addr.delete();
      wr_data.delete();
      send_byte(8'h01); send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      send_byte(8'h43);
      @(negedge clk);
      check_status("t6_bad", 1'b0, 1'b1, 1'b0, 1'b1);
      check("t6_nwr", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) check("t6_data", wr_data[0], 32'h0050_0013);
      pulse_restart("t6_rs");
`endif

      // Three words with two idle cycles between bytes
      for (int i = 0; i < 3; i++) tw[i] = $urandom;
      do_load(3, 2, 1'b0, "t2");
      pulse_restart("t2_rs");

      // Bad headers
      send_byte(8'h00);
      @(negedge clk);
      check_status("t3_h00", 1'b0, 1'b1, 1'b0, 1'b1);
      pulse_restart("t3_rs0");
      send_byte(8'h21);
      @(negedge clk);
      check_status("t3_h21", 1'b0, 1'b1, 1'b0, 1'b1);
      pulse_restart("t3_rs1");

      // Random headers: valid only when 1..N_WORDS
      for (int it = 0; it < 8; it++) begin
         h = (it < 4) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
         valid = (h >= 1) && (h <= N_WORDS);
         send_byte(8'(h));
         @(negedge clk);
         check($sformatf("hdr%02h_erro", h),  {31'b0, erro},       {31'b0, ~valid});
         check($sformatf("hdr%02h_ready", h), {31'b0, byte_ready}, {31'b0, valid});
         if (valid) begin
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end else begin
            pulse_restart("hdr_rs");
         end
      end

      // Full memory, no wrap and no extra write
      for (int i = 0; i < N_WORDS; i++) tw[i] = 32'h1000_0000 + 32'(i);
      do_load(N_WORDS, 0, 1'b0, "t4");
      pulse_restart("t4_rs");

      // Asynchronous reset in the middle of a load
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tw[0] = 32'hDDCC_BBAA;
      do_load(1, 0, 1'b0, "t5");
      pulse_restart("t5_rs");

      // Randomized loads
      for (int it = 0; it < 5; it++) begin
         cnt = $urandom_range(1, 8);
         for (int i = 0; i < cnt; i++) tw[i] = $urandom;
         do_load(cnt, $urandom_range(0, 2), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
         pulse_restart($sformatf("rnd%0d_rs", it));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
